sha256_round_ctrl: RTL and testbench
====================================

Name: sha256_round_ctrl

Overview:
- Sequencing controller for one SHA-256 compression block on the CSA-based round datapath (CSA7_2 trees for T1/T2 and the final H-add).
- Accepts a start request and 16 message words over a valid/ready handshake, steps the round datapath through all rounds and issues the K-ROM address and schedule/word selects.
- Triggers the final H += working-variable update and pulses done.
- The datapath owns all 32-bit storage; this block owns only state, round index and strobes.

Parameters:
- ROUNDS, 64, compression rounds per block (legal range 17..64; 64 for SHA-256).
- MSG_WORDS, 16, rounds fed from the external message port.
- RND_W, 6, width of the round index and K address; must satisfy 2^RND_W >= ROUNDS.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- i_start  in  1  start one block; sampled only in IDLE.
- i_first  in  1  first block of message; sampled with accepted i_start.
- i_abort  in  1  synchronous abort of the current block.
- i_msg_valid  in  1  external message word valid.
- o_msg_ready  out  1  controller takes a message word this cycle when valid.
- o_k_addr  out  RND_W  K-constant ROM address (= current round).
- o_round  out  RND_W  current round index.
- o_w_sel  out  1  0: W from message port; 1: W from schedule recurrence.
- o_sched_en  out  1  shift the W[t] window.
- o_rnd_en  out  1  advance working variables a..h by one round.
- o_iv_load  out  1  load H0..H7 with IV constants.
- o_wv_load  out  1  copy H (or IV when o_iv_load) into a..h.
- o_h_update  out  1  H[i] += working variable i.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle block-complete pulse.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. No asynchronous logic.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, round=0, first_q=0.
  - All strobes, o_busy and o_done are 0; o_k_addr=o_round=0.
  - Reset mid-block discards the block. No o_h_update or o_done follows.
- Registers: state, round, first_q. Strobes are decoded combinationally from these registers plus i_msg_valid. No strobe depends on i_start.
- States:
  - IDLE:
    - i_start=1 -> INIT; first_q<=i_first; round<=0.
  - INIT (1 cycle):
    - o_wv_load=1; o_iv_load=first_q.
    - -> ROUND.
  - ROUND with round<MSG_WORDS:
    - o_msg_ready=1, o_w_sel=0.
    - Step condition: i_msg_valid=1. Then o_rnd_en=1 and o_sched_en=1, and round increments.
    - With i_msg_valid=0: stall. round is held and o_rnd_en=o_sched_en=0.
  - ROUND with round>=MSG_WORDS:
    - o_msg_ready=0, o_w_sel=1.
    - o_rnd_en=o_sched_en=1 every cycle; round increments each cycle.
  - ROUND exit: a step taken at round==ROUNDS-1 -> FINAL; round<=0.
  - FINAL (1 cycle): o_h_update=1 -> DONE.
  - DONE (1 cycle): o_done=1 -> IDLE.
- o_k_addr and o_round equal round in every state (0 outside ROUND).
- Latency with no stalls: accepted start at edge E0. INIT occupies E0..E1; ROUND occupies ROUNDS cycles; FINAL one cycle; o_done is high in cycle E0+ROUNDS+2 (cycle 66 for ROUNDS=64).
- Each stall cycle adds exactly one cycle of latency.
- Message handshake: a word transfers exactly when o_msg_ready & i_msg_valid. Exactly MSG_WORDS transfers per block. i_msg_valid outside ROUND is ignored.
- i_start outside IDLE (including in DONE) is ignored. No queuing.
- i_abort=1 in INIT/ROUND/FINAL/DONE:
  - All strobes for that cycle are forced to 0.
  - Next state IDLE; round<=0.
  - H is unchanged and no o_done is issued.
- i_abort in IDLE has no effect.
- rst_n overrides i_abort; i_abort overrides i_msg_valid.
- Round counter never wraps. It is cleared on the ROUND->FINAL transition and on abort.

Optional Feature:
- Macro: SHA256_CTRL_STALL_CNT_EN.
- Defined:
  - Adds output o_stall_cnt (16 bits).
  - Counts ROUND cycles with round<MSG_WORDS and i_msg_valid=0.
  - Cleared to 0 on reset and on an accepted i_start; saturates at 16'hFFFF.
  - Holds its value after o_done until the next accepted start.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with i_start=1 -> all outputs 0, o_busy=0. Release -> block starts on the next edge.
- Full block, i_first=1, i_msg_valid tied 1, start at edge E0:
  - o_iv_load and o_wv_load pulse once (E0..E1).
  - 16 transfers; o_rnd_en pulses 64 times; o_w_sel rises exactly at round 16.
  - o_k_addr runs 0..63; one o_h_update; o_done at cycle E0+66.
- Stall: drop i_msg_valid for 3 cycles at round 5 -> round holds at 5 with no o_rnd_en; o_done at E0+69; o_stall_cnt=3 with macro.
- i_first=0 block -> o_iv_load never asserted; o_wv_load pulses once.
- i_abort at round 20 -> next cycle IDLE, round=0, o_busy=0; no o_h_update, no o_done. A new i_start completes normally.
- i_start held high throughout -> first start accepted; pulses during ROUND/DONE ignored; next block begins the cycle after IDLE is re-entered; exactly one o_done per accepted start.

Source files
------------

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: state/round sequencer for one SHA-256 compression block on the CSA round datapath.
// Optional macro SHA256_CTRL_STALL_CNT_EN adds o_stall_cnt (message-stall cycle counter).
module sha256_round_ctrl #(
  parameter int ROUNDS    = 64,
  parameter int MSG_WORDS = 16,
  parameter int RND_W     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_first,
  input  logic             i_abort,
  input  logic             i_msg_valid,
  output logic             o_msg_ready,
  output logic [RND_W-1:0] o_k_addr,
  output logic [RND_W-1:0] o_round,
  output logic             o_w_sel,
  output logic             o_sched_en,
  output logic             o_rnd_en,
  output logic             o_iv_load,
  output logic             o_wv_load,
  output logic             o_h_update,
  output logic             o_busy,
`ifdef SHA256_CTRL_STALL_CNT_EN
  output logic [15:0]      o_stall_cnt,
`endif
  output logic             o_done
);
  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;
  state_t state, state_n;
  logic [RND_W-1:0] round, round_n;
  logic first_q, first_n, run, msg_ph, step, last;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      round   <= '0;
      first_q <= 1'b0;
    end else begin
      state   <= state_n;
      round   <= round_n;
      first_q <= first_n;
    end
  end
  // abort masks every strobe of the cycle it is seen in
  always_comb begin
    run         = state == ROUND && !i_abort;
    msg_ph      = round < RND_W'(MSG_WORDS);
    last        = round == RND_W'(ROUNDS - 1);
    step        = run && (!msg_ph || i_msg_valid);
    o_msg_ready = run && msg_ph;
    o_w_sel     = run && !msg_ph;
    o_sched_en  = step;
    o_rnd_en    = step;
    o_wv_load   = state == INIT && !i_abort;
    o_iv_load   = o_wv_load && first_q;
    o_h_update  = state == FINAL && !i_abort;
    o_done      = state == DONE && !i_abort;
    o_busy      = state != IDLE;
    o_k_addr    = round;
    o_round     = round;
    state_n     = state;
    round_n     = round;
    first_n     = first_q;
    if (i_abort && state != IDLE) begin
      state_n = IDLE;
      round_n = '0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          state_n = INIT;
          round_n = '0;
          first_n = i_first;
        end
        INIT: state_n = ROUND;
        ROUND: if (step) begin
          state_n = last ? FINAL : ROUND;
          round_n = last ? '0 : round + RND_W'(1);
        end
        FINAL: state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end
`ifdef SHA256_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n || (state == IDLE && i_start))
      stall_cnt <= '0;
    else if (o_msg_ready && !i_msg_valid && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
  assign o_stall_cnt = stall_cnt;
`endif
endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl: randomized and directed checks of sha256_round_ctrl against a progress-index model.
module tb_sha256_round_ctrl;
  localparam int R = 64;
  localparam int M = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0, i_start = 1'b0, i_first = 1'b0, i_abort = 1'b0, i_msg_valid = 1'b0;
  logic msg_ready, w_sel, sched_en, rnd_en, iv_load, wv_load, h_update, busy, done;
  logic [5:0] k_addr, round;
`ifdef SHA256_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  always #5 clk = ~clk;
  sha256_round_ctrl #(.ROUNDS(R), .MSG_WORDS(M), .RND_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_first(i_first), .i_abort(i_abort),
    .i_msg_valid(i_msg_valid), .o_msg_ready(msg_ready), .o_k_addr(k_addr), .o_round(round),
    .o_w_sel(w_sel), .o_sched_en(sched_en), .o_rnd_en(rnd_en), .o_iv_load(iv_load),
    .o_wv_load(wv_load), .o_h_update(h_update), .o_busy(busy),
`ifdef SHA256_CTRL_STALL_CNT_EN
    .o_stall_cnt(stall_cnt),
`endif
    .o_done(done)
  );
  int n_cmp = 0, n_bad = 0;
  // model: t = -1 INIT, 0..R-1 rounds, R final, R+1 done
  bit act = 0, first_m = 0;
  int t = 0, cyc = 0, start_edge = 0, m_acc = 0, m_done = 0, m_stall = 0;
  int xfer, rnd, wv, iv, hup, dn, done_cyc, wsel_round, ksum;
  bit wsel_seen;
  task automatic chk(input string name, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, a, e, cyc);
    end
  endtask
  task automatic clr();
    xfer = 0; rnd = 0; wv = 0; iv = 0; hup = 0; dn = 0; ksum = 0;
    done_cyc = -1; wsel_round = -1; wsel_seen = 0;
  endtask
  task automatic tick();
    bit ir, lv, rdy_e, wsel_e, step_e;
    logic [5:0] r_e;
    int a, e;
    #1;
    ir = act && t >= 0 && t < R;
    lv = act && !i_abort;
    rdy_e = lv && ir && t < M;
    wsel_e = lv && ir && t >= M;
    step_e = wsel_e || (rdy_e && i_msg_valid);
    r_e = ir ? 6'(t) : 6'd0;
    e = int'({act, rdy_e, wsel_e, step_e, step_e, lv && t == -1 && first_m, lv && t == -1,
              lv && t == R, lv && t == R + 1, r_e, r_e});
    a = int'({busy, msg_ready, w_sel, sched_en, rnd_en, iv_load, wv_load, h_update, done, round, k_addr});
    chk("outputs", a, e);
`ifdef SHA256_CTRL_STALL_CNT_EN
    chk("stall_cnt", int'(stall_cnt), m_stall);
`endif
    xfer += int'(msg_ready && i_msg_valid);
    rnd += int'(rnd_en);
    wv += int'(wv_load);
    iv += int'(iv_load);
    hup += int'(h_update);
    dn += int'(done);
    if (rnd_en) ksum += int'(k_addr);
    if (done) done_cyc = cyc - start_edge;
    if (w_sel && !wsel_seen) begin
      wsel_seen = 1;
      wsel_round = int'(round);
    end
    @(posedge clk);
    if (!rst_n) begin
      act = 0; t = 0; m_stall = 0;
    end else if (!act) begin
      if (i_start) begin
        act = 1; t = -1; first_m = i_first; start_edge = cyc + 1; m_acc++; m_stall = 0;
      end
    end else if (i_abort) act = 0;
    else if (ir && t < M && !i_msg_valid) m_stall = (m_stall == 65535) ? m_stall : m_stall + 1;
    else if (t == R + 1) begin
      act = 0; m_done++;
    end else t++;
    cyc++;
    @(negedge clk);
  endtask
  task automatic start_block(input bit f);
    i_first = f; i_start = 1; tick(); i_start = 0;
  endtask
  initial begin
    int acc0;
    @(posedge clk); @(negedge clk);
    i_start = 1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_round", round, 0);
    // full block, start accepted on the edge right after reset release
    clr(); rst_n = 1; i_first = 1; i_msg_valid = 1; tick(); i_start = 0;
    repeat (70) tick();
    chk("a_wv", wv, 1); chk("a_iv", iv, 1); chk("a_xfer", xfer, 16); chk("a_rnd", rnd, 64);
    chk("a_hup", hup, 1); chk("a_done", dn, 1); chk("a_lat", done_cyc, 66);
    chk("a_wsel_round", wsel_round, 16); chk("a_ksum", ksum, 2016);
    // three-cycle stall at round 5
    clr(); start_block(1);
    repeat (6) tick();
    i_msg_valid = 0;
    repeat (3) tick();
    chk("b_hold_round", round, 5); chk("b_hold_rnd", rnd, 5);
`ifdef SHA256_CTRL_STALL_CNT_EN
    chk("b_stall_cnt", stall_cnt, 3);
`endif
    i_msg_valid = 1;
    repeat (70) tick();
    chk("b_lat", done_cyc, 69); chk("b_rnd", rnd, 64); chk("b_xfer", xfer, 16); chk("b_done", dn, 1);
`ifdef SHA256_CTRL_STALL_CNT_EN
    chk("b_stall_hold", stall_cnt, 3);
`endif
    // continuation block
    clr(); start_block(0);
    repeat (70) tick();
    chk("c_iv", iv, 0); chk("c_wv", wv, 1); chk("c_done", dn, 1);
    // abort at round 20, then a clean block
    clr(); start_block(1);
    repeat (21) tick();
    chk("d_round", round, 20);
    i_abort = 1; tick(); i_abort = 0;
    chk("d_busy", busy, 0); chk("d_round0", round, 0);
    repeat (70) tick();
    chk("d_hup", hup, 0); chk("d_done", dn, 0);
    clr(); start_block(1);
    repeat (70) tick();
    chk("d2_done", dn, 1); chk("d2_lat", done_cyc, 66);
    // i_start held high: back-to-back blocks, one done per accepted start
    clr(); acc0 = m_acc; i_start = 1;
    repeat (140) tick();
    chk("e_done2", dn, 2);
    i_start = 0;
    repeat (80) tick();
    chk("e_done3", dn, 3); chk("e_acc", m_acc - acc0, 3);
    // random traffic
    clr(); m_done = 0;
    for (int i = 0; i < 3000; i++) begin
      i_start = ($urandom % 8) == 0;
      i_first = $urandom % 2;
      i_msg_valid = ($urandom % 4) != 0;
      i_abort = ($urandom % 150) == 0;
      rst_n = ($urandom % 400) != 0;
      tick();
    end
    rst_n = 1; i_start = 0; i_abort = 0; i_msg_valid = 1;
    repeat (80) tick();
    chk("f_done", dn, m_done);
    chk("f_idle", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
